// File: rtl/redmule_pkg.sv
// Shared types and constants for the RedMulE MX store path.
package redmule_pkg;

  localparam int unsigned MX_VAL_W        = 256;
  localparam int unsigned MX_EXP_W        = 8;
  localparam int unsigned MX_DATAW_ALIGN  = 2 * MX_VAL_W;
  localparam int unsigned MX_EXP_PER_WORD = MX_DATAW_ALIGN / MX_EXP_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLUSH_VAL = 2'd1,
    FLUSH_EXP = 2'd2,
    DONE      = 2'd3
  } mx_pack_state_e;

  // Byte strobe with the lowest nbytes bytes set.
  function automatic logic [MX_DATAW_ALIGN/8-1:0] mx_low_strb(input logic [6:0] nbytes);
    logic [MX_DATAW_ALIGN/8-1:0] strb;
    for (int i = 0; i < MX_DATAW_ALIGN/8; i++) begin
      strb[i] = (i < int'(nbytes));
    end
    return strb;
  endfunction

endpackage

// File: rtl/redmule_mx_store_packer_if.sv
// Stream bundle of the MX store packer: value/exponent beats in, packed words out.
interface redmule_mx_store_packer_if;
  import redmule_pkg::*;

  logic                        val_valid;
  logic                        val_ready;
  logic [MX_VAL_W-1:0]         val_data;
  logic                        exp_valid;
  logic                        exp_ready;
  logic [MX_EXP_W-1:0]         exp_data;
  logic                        data_valid;
  logic                        data_ready;
  logic [MX_DATAW_ALIGN-1:0]   data;
  logic [MX_DATAW_ALIGN/8-1:0] data_strb;
  logic                        expw_valid;
  logic                        expw_ready;
  logic [MX_DATAW_ALIGN-1:0]   expw_data;
  logic [MX_DATAW_ALIGN/8-1:0] expw_strb;

  modport slave (
    input  val_valid, val_data, exp_valid, exp_data, data_ready, expw_ready,
    output val_ready, exp_ready, data_valid, data, data_strb, expw_valid, expw_data, expw_strb
  );

  modport master (
    output val_valid, val_data, exp_valid, exp_data, data_ready, expw_ready,
    input  val_ready, exp_ready, data_valid, data, data_strb, expw_valid, expw_data, expw_strb
  );

endinterface

// File: rtl/redmule_mx_exp_packer.sv
// Packs 64 shared exponents into one store word; emits a byte-strobed partial word on flush.
module redmule_mx_exp_packer
  import redmule_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        accept_en_i,
  input  logic                        exp_valid_i,
  output logic                        exp_ready_o,
  input  logic [MX_EXP_W-1:0]         exp_data_i,
  output logic                        word_valid_o,
  input  logic                        word_ready_i,
  output logic [MX_DATAW_ALIGN-1:0]   word_data_o,
  output logic [MX_DATAW_ALIGN/8-1:0] word_strb_o,
  input  logic                        flush_i,
  output logic                        flushed_o
);

  logic [5:0]                  cnt_q, cnt_d;
  logic [MX_DATAW_ALIGN-1:0]   acc_q, acc_d;
  logic                        word_valid_q, word_valid_d;
  logic [MX_DATAW_ALIGN-1:0]   word_data_q, word_data_d;
  logic [MX_DATAW_ALIGN/8-1:0] word_strb_q, word_strb_d;
  logic                        out_free;
  logic                        exp_fire;

  assign out_free    = !word_valid_q || word_ready_i;
  assign exp_ready_o = accept_en_i && ((cnt_q != 6'd63) || out_free);
  assign exp_fire    = exp_valid_i && exp_ready_o;
  assign flushed_o   = flush_i && ((cnt_q == 6'd0) || out_free);

  // The accumulator is zeroed on every word boundary so partial words carry zero in unused bytes.
  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    word_valid_d = word_valid_q && !word_ready_i;
    word_data_d  = word_data_q;
    word_strb_d  = word_strb_q;
    if (exp_fire) begin
      if (cnt_q == 6'd63) begin
        word_data_d  = {exp_data_i, acc_q[MX_DATAW_ALIGN-MX_EXP_W-1:0]};
        word_strb_d  = {(MX_DATAW_ALIGN/8){1'b1}};
        word_valid_d = 1'b1;
        cnt_d        = 6'd0;
        acc_d        = {MX_DATAW_ALIGN{1'b0}};
      end else begin
        acc_d[{cnt_q, 3'b000} +: MX_EXP_W] = exp_data_i;
        cnt_d = cnt_q + 6'd1;
      end
    end else if (flushed_o && (cnt_q != 6'd0)) begin
      word_data_d  = acc_q;
      word_strb_d  = mx_low_strb({1'b0, cnt_q});
      word_valid_d = 1'b1;
      cnt_d        = 6'd0;
      acc_d        = {MX_DATAW_ALIGN{1'b0}};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Exponent accumulator and output word register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= 6'd0;
      acc_q        <= {MX_DATAW_ALIGN{1'b0}};
      word_valid_q <= 1'b0;
      word_data_q  <= {MX_DATAW_ALIGN{1'b0}};
      word_strb_q  <= {(MX_DATAW_ALIGN/8){1'b0}};
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      word_strb_q  <= word_strb_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_data_o  = word_data_q;
  assign word_strb_o  = word_strb_q;

endmodule

// File: rtl/redmule_mx_store_packer.sv
// Packs MX value beats and shared exponents into store words, with end-of-tile flush.
// Optional perf counters: define REDMULE_MX_STORE_PACKER_PERF_EN.
module redmule_mx_store_packer
  import redmule_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       enable_i,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  redmule_mx_store_packer_if.slave   bus,
  output logic [31:0]                perf_words_o,
  output logic [31:0]                perf_stall_o
);

  mx_pack_state_e              state_q, state_d;
  logic                        sync_rst;
  logic                        half_q, half_d;
  logic [MX_VAL_W-1:0]         val_lo_q, val_lo_d;
  logic                        data_valid_q, data_valid_d;
  logic [MX_DATAW_ALIGN-1:0]   data_q, data_d;
  logic [MX_DATAW_ALIGN/8-1:0] data_strb_q, data_strb_d;
  logic                        flush_done_q, flush_done_d;
  logic                        data_free, val_fire;
  logic                        accept_en, val_flush_load, exp_flush_req, exp_flushed;

  assign sync_rst  = rst_i || clear_i;
  assign data_free = !data_valid_q || bus.data_ready;
  assign bus.val_ready = accept_en && (!half_q || data_free);
  assign val_fire  = bus.val_valid && bus.val_ready;

  // State register.
  always_ff @(posedge clk_i) begin
    if (sync_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = flush_i ? FLUSH_VAL : IDLE;
      FLUSH_VAL: state_d = (!half_q || data_free) ? FLUSH_EXP : FLUSH_VAL;
      FLUSH_EXP: state_d = exp_flushed ? DONE : FLUSH_EXP;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    accept_en      = 1'b0;
    val_flush_load = 1'b0;
    exp_flush_req  = 1'b0;
    case (state_q)
      IDLE:      accept_en      = enable_i;
      FLUSH_VAL: val_flush_load = half_q && data_free;
      FLUSH_EXP: exp_flush_req  = 1'b1;
      default:   accept_en      = 1'b0;
    endcase
    flush_done_d = exp_flush_req && exp_flushed;
  end

  // Value path: pair beats into a word, or push out the lone low half on flush.
  always_comb begin
    half_d       = half_q;
    val_lo_d     = val_lo_q;
    data_valid_d = data_valid_q && !bus.data_ready;
    data_d       = data_q;
    data_strb_d  = data_strb_q;
    if (val_fire && !half_q) begin
      val_lo_d = bus.val_data;
      half_d   = 1'b1;
    end else if (val_fire) begin
      data_d       = {bus.val_data, val_lo_q};
      data_strb_d  = {(MX_DATAW_ALIGN/8){1'b1}};
      data_valid_d = 1'b1;
      half_d       = 1'b0;
    end else if (val_flush_load) begin
      data_d       = {{MX_VAL_W{1'b0}}, val_lo_q};
      data_strb_d  = {{(MX_VAL_W/8){1'b0}}, {(MX_VAL_W/8){1'b1}}};
      data_valid_d = 1'b1;
      half_d       = 1'b0;
    end else begin
      half_d = half_q;
    end
  end

  // Value-path and flush-done registers.
  always_ff @(posedge clk_i) begin
    if (sync_rst) begin
      half_q       <= 1'b0;
      val_lo_q     <= {MX_VAL_W{1'b0}};
      data_valid_q <= 1'b0;
      data_q       <= {MX_DATAW_ALIGN{1'b0}};
      data_strb_q  <= {(MX_DATAW_ALIGN/8){1'b0}};
      flush_done_q <= 1'b0;
    end else begin
      half_q       <= half_d;
      val_lo_q     <= val_lo_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      data_strb_q  <= data_strb_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.data_valid = data_valid_q;
  assign bus.data       = data_q;
  assign bus.data_strb  = data_strb_q;
  assign flush_done_o   = flush_done_q;

  redmule_mx_exp_packer u_exp_packer (
    .clk_i        (clk_i),
    .rst_i        (sync_rst),
    .accept_en_i  (accept_en),
    .exp_valid_i  (bus.exp_valid),
    .exp_ready_o  (bus.exp_ready),
    .exp_data_i   (bus.exp_data),
    .word_valid_o (bus.expw_valid),
    .word_ready_i (bus.expw_ready),
    .word_data_o  (bus.expw_data),
    .word_strb_o  (bus.expw_strb),
    .flush_i      (exp_flush_req),
    .flushed_o    (exp_flushed)
  );

`ifdef REDMULE_MX_STORE_PACKER_PERF_EN
  logic [31:0] perf_words_q, perf_stall_q;

  // Saturating handshake and stall counters.
  always_ff @(posedge clk_i) begin
    if (sync_rst) begin
      perf_words_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (data_valid_q && bus.data_ready && (perf_words_q != 32'hFFFF_FFFF)) begin
        perf_words_q <= perf_words_q + 32'd1;
      end
      if (data_valid_q && !bus.data_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_words_o = perf_words_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_words_o = 32'd0;
  assign perf_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_redmule_mx_store_packer.sv
// Randomized and directed bench for redmule_mx_store_packer against a queue-based word model.
module tb_redmule_mx_store_packer;

  logic        clk = 1'b0;
  logic        rst_i, clear_i, enable_i, flush_i, flush_done_o;
  logic [31:0] perf_words_o, perf_stall_o;
  int          n_checks = 0;
  int          n_pass   = 0;

  redmule_mx_store_packer_if bus();

  redmule_mx_store_packer dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .enable_i     (enable_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .bus          (bus),
    .perf_words_o (perf_words_o),
    .perf_stall_o (perf_stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", tag, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: accepted beats/exponents become expected words in order.
  logic [511:0] m_dq[$], m_ds[$], m_eq[$], m_es[$];
  logic [255:0] m_lo;
  bit           m_lo_vld;
  logic [7:0]   m_exp[$];
  bit           m_busy;
  int           m_flushes, m_dones;
  logic [31:0]  m_words;

  function automatic logic [511:0] pack_exps();
    logic [511:0] w = '0;
    for (int k = 0; k < m_exp.size(); k++) w[k*8 +: 8] = m_exp[k];
    return w;
  endfunction

  function automatic logic [511:0] low_strb(input int n);
    logic [511:0] s = '0;
    for (int k = 0; k < n; k++) s[k] = 1'b1;
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst_i || clear_i) begin
      m_dq.delete(); m_ds.delete(); m_eq.delete(); m_es.delete(); m_exp.delete();
      m_lo_vld = 1'b0;
      if (m_busy) m_flushes--;
      m_busy  = 1'b0;
      m_words = 32'd0;
    end else begin
      if (bus.data_valid && bus.data_ready) begin
        if (m_dq.size() == 0) chk_eq("data_unexpected", bus.data_valid, 1'b0);
        else begin
          chk_eq("data_word", bus.data, m_dq.pop_front());
          chk_eq("data_strb", bus.data_strb, m_ds.pop_front());
          m_words++;
        end
      end
      if (bus.expw_valid && bus.expw_ready) begin
        if (m_eq.size() == 0) chk_eq("expw_unexpected", bus.expw_valid, 1'b0);
        else begin
          chk_eq("expw_word", bus.expw_data, m_eq.pop_front());
          chk_eq("expw_strb", bus.expw_strb, m_es.pop_front());
        end
      end
      if ((!enable_i || m_busy) && bus.val_valid) chk_eq("val_ready_gated", bus.val_ready, 1'b0);
      if ((!enable_i || m_busy) && bus.exp_valid) chk_eq("exp_ready_gated", bus.exp_ready, 1'b0);
      if (flush_done_o) chk_eq("flush_done_expected", flush_done_o, m_busy);
      if (bus.val_valid && bus.val_ready) begin
        if (m_lo_vld) begin
          m_dq.push_back({bus.val_data, m_lo});
          m_ds.push_back(low_strb(64));
          m_lo_vld = 1'b0;
        end else begin
          m_lo = bus.val_data;
          m_lo_vld = 1'b1;
        end
      end
      if (bus.exp_valid && bus.exp_ready) begin
        m_exp.push_back(bus.exp_data);
        if (m_exp.size() == 64) begin
          m_eq.push_back(pack_exps());
          m_es.push_back(low_strb(64));
          m_exp.delete();
        end
      end
      if (flush_i && !m_busy) begin
        if (m_lo_vld) begin
          m_dq.push_back({256'd0, m_lo});
          m_ds.push_back(low_strb(32));
          m_lo_vld = 1'b0;
        end
        if (m_exp.size() > 0) begin
          m_eq.push_back(pack_exps());
          m_es.push_back(low_strb(m_exp.size()));
          m_exp.delete();
        end
        m_busy = 1'b1;
        m_flushes++;
      end else if (flush_done_o) begin
        m_busy = 1'b0;
        m_dones++;
      end
    end
  end

  task automatic idle_inputs();
    bus.val_valid = 1'b0; bus.exp_valid = 1'b0; flush_i = 1'b0; clear_i = 1'b0;
    bus.data_ready = 1'b1; bus.expw_ready = 1'b1; enable_i = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [255:0] b[0:5];
  logic [511:0] w;
  int           idx, guard;
  bit           rdy, prev_flush;

  initial begin
    bus.val_data = '0; bus.exp_data = '0;
    m_busy = 1'b0; m_lo_vld = 1'b0; m_flushes = 0; m_dones = 0; m_words = 32'd0;
    do_reset();

    // Reset state.
    chk_eq("rst_data_valid", bus.data_valid, 1'b0);
    chk_eq("rst_expw_valid", bus.expw_valid, 1'b0);
    chk_eq("rst_data_strb", bus.data_strb, 64'd0);
    chk_eq("rst_expw_strb", bus.expw_strb, 64'd0);
    chk_eq("rst_flush_done", flush_done_o, 1'b0);
    chk_eq("rst_perf_words", perf_words_o, 32'd0);
    bus.val_valid = 1'b1; #1;
    chk_eq("rst_val_ready", bus.val_ready, 1'b1);

    // Two beats A, B form {B,A} the cycle after B.
    bus.val_data = {32{8'hAA}}; step();
    chk_eq("ab_not_yet", bus.data_valid, 1'b0);
    bus.val_data = {32{8'h55}}; step();
    chk_eq("ab_valid", bus.data_valid, 1'b1);
    chk_eq("ab_data", bus.data, {{32{8'h55}}, {32{8'hAA}}});
    chk_eq("ab_strb", bus.data_strb, {64{1'b1}});
    bus.val_valid = 1'b0; step();

    // 64 exponents 0..63, then the 65th is accepted straight away.
    do_reset();
    bus.exp_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      bus.exp_data = 8'(k);
      if (k == 63) chk_eq("exp63_not_yet", bus.expw_valid, 1'b0);
      step();
    end
    for (int k = 0; k < 64; k++) w[k*8 +: 8] = 8'(k);
    chk_eq("exp64_valid", bus.expw_valid, 1'b1);
    chk_eq("exp64_data", bus.expw_data, w);
    chk_eq("exp64_strb", bus.expw_strb, {64{1'b1}});
    bus.exp_data = 8'hC0; #1;
    chk_eq("exp65_ready", bus.exp_ready, 1'b1);
    step(); bus.exp_valid = 1'b0; step();

    // Three beats and five exponents, then flush.
    do_reset();
    for (int i = 0; i < 3; i++) b[i] = rnd256();
    for (int i = 0; i < 5; i++) begin
      bus.exp_valid = 1'b1; bus.exp_data = 8'(8'h10 + i);
      bus.val_valid = (i < 3); bus.val_data = b[i < 3 ? i : 0];
      step();
    end
    bus.exp_valid = 1'b0; bus.val_valid = 1'b0; flush_i = 1'b1; step();
    flush_i = 1'b0;
    chk_eq("fl_done_e0", flush_done_o, 1'b0);
    step();
    chk_eq("fl_val_valid", bus.data_valid, 1'b1);
    chk_eq("fl_val_strb", bus.data_strb, 64'h0000_0000_FFFF_FFFF);
    chk_eq("fl_val_data", bus.data, {256'd0, b[2]});
    chk_eq("fl_done_e1", flush_done_o, 1'b0);
    step();
    chk_eq("fl_exp_valid", bus.expw_valid, 1'b1);
    chk_eq("fl_exp_strb", bus.expw_strb, 64'h1F);
    chk_eq("fl_exp_data", bus.expw_data, 512'h14_1312_1110);
    chk_eq("fl_done_e2", flush_done_o, 1'b1);
    step();
    chk_eq("fl_done_e3", flush_done_o, 1'b0);

    // Downstream stall of 10 cycles with beats still offered.
    do_reset();
    for (int i = 0; i < 6; i++) b[i] = rnd256();
    bus.val_valid = 1'b1; bus.val_data = b[0]; step();
    bus.val_data = b[1]; step();
    bus.data_ready = 1'b0; idx = 2;
    for (int c = 0; c < 10; c++) begin
      bus.val_data = b[idx]; #1; rdy = bus.val_ready;
      step();
      if (rdy) idx++;
    end
    chk_eq("stall_accepted", 32'(idx), 32'd3);
    bus.val_data = b[idx]; #1;
    chk_eq("stall_val_ready", bus.val_ready, 1'b0);
`ifdef REDMULE_MX_STORE_PACKER_PERF_EN
    chk_eq("stall_perf", perf_stall_o, 32'd10);
`else
    chk_eq("stall_perf", perf_stall_o, 32'd0);
`endif
    bus.data_ready = 1'b1;
    guard = 0;
    while (idx < 6 && guard < 20) begin
      bus.val_data = b[idx]; #1; rdy = bus.val_ready;
      step(); guard++;
      if (rdy) idx++;
    end
    chk_eq("stall_drained", 32'(idx), 32'd6);
    bus.val_valid = 1'b0; step(); step();

    // Reset while in FLUSH_EXP.
    do_reset();
    b[0] = rnd256();
    bus.val_valid = 1'b1; bus.val_data = b[0]; bus.exp_valid = 1'b1; bus.exp_data = 8'h77; step();
    bus.val_valid = 1'b0; bus.exp_valid = 1'b0; flush_i = 1'b1; step();
    flush_i = 1'b0; step();
    rst_i = 1'b1; step(); rst_i = 1'b0;
    chk_eq("rf_data_valid", bus.data_valid, 1'b0);
    chk_eq("rf_expw_valid", bus.expw_valid, 1'b0);
    chk_eq("rf_data", bus.data, 512'd0);
    chk_eq("rf_strb", bus.data_strb, 64'd0);
    for (int c = 0; c < 5; c++) begin
      chk_eq("rf_no_done", flush_done_o, 1'b0);
      step();
    end
    b[1] = rnd256(); b[2] = rnd256();
    bus.val_valid = 1'b1; bus.val_data = b[1]; step();
    bus.val_data = b[2]; step();
    chk_eq("rf_low_half", bus.data, {b[2], b[1]});
    bus.val_valid = 1'b0; step();

    // Flush with nothing pending.
    do_reset();
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk_eq("fe_done_e0", flush_done_o, 1'b0);
    step();
    chk_eq("fe_done_e1", flush_done_o, 1'b0);
    chk_eq("fe_dv_e1", bus.data_valid, 1'b0);
    step();
    chk_eq("fe_done_e2", flush_done_o, 1'b1);
    chk_eq("fe_dv_e2", bus.data_valid, 1'b0);
    chk_eq("fe_ev_e2", bus.expw_valid, 1'b0);
    step();
    chk_eq("fe_done_e3", flush_done_o, 1'b0);

    // Randomized traffic.
    do_reset();
    prev_flush = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      bus.val_valid  = ($urandom_range(0, 3) != 0);
      bus.val_data   = rnd256();
      bus.exp_valid  = ($urandom_range(0, 3) != 0);
      bus.exp_data   = 8'($urandom());
      bus.data_ready = ($urandom_range(0, 3) != 0);
      bus.expw_ready = ($urandom_range(0, 4) != 0);
      enable_i       = ($urandom_range(0, 9) != 0);
      flush_i        = !prev_flush && ($urandom_range(0, 39) == 0);
      clear_i        = ($urandom_range(0, 699) == 0);
      prev_flush     = flush_i;
      step();
    end
    idle_inputs();
    guard = 0;
    while (m_busy && guard < 50) begin step(); guard++; end
    flush_i = 1'b1; step(); flush_i = 1'b0;
    guard = 0;
    while ((m_busy || m_dq.size() != 0 || m_eq.size() != 0) && guard < 50) begin step(); guard++; end
    chk_eq("drain_timeout", 32'(guard), 32'(guard < 50 ? guard : 0));
    step(); step();
    chk_eq("drain_data_q", 32'(m_dq.size()), 32'd0);
    chk_eq("drain_expw_q", 32'(m_eq.size()), 32'd0);
    chk_eq("flush_count", 32'(m_dones), 32'(m_flushes));
`ifdef REDMULE_MX_STORE_PACKER_PERF_EN
    chk_eq("perf_words", perf_words_o, m_words);
`else
    chk_eq("perf_words", perf_words_o, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
